branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
Parametrised branch resolution and prediction block for the pipelined core. It combines the existing BrOp compare/jump decode with a bimodal branch history table (BHT) of 2-bit saturating counters. The fetch stage queries a prediction. The execute stage resolves the branch, flags a mispredict and trains the table. Saturating performance counters track branches and mispredicts.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, minimum 2
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
f_pc  in  XLEN  fetch-stage PC, used for lookup
f_pred_taken  out  1  prediction for f_pc; combinational
ex_valid  in  1  execute-stage instruction is valid
ex_pc  in  XLEN  PC of the resolving instruction
ex_a  in  XLEN  rs1 operand, signed
ex_b  in  XLEN  rs2 operand, signed
ex_brop  in  5  [4]=unconditional jump, [3]=conditional branch, [2:0]=funct3
ex_pred_taken  in  1  prediction that was carried down the pipe with this instruction
ex_taken  out  1  resolved direction; combinational
ex_mispredict  out  1  ex_valid & (ex_taken != ex_pred_taken); combinational
clr_stats  in  1  synchronous clear of the performance counters
perf_branches  out  CNT_W  count of resolved conditional branches
perf_mispredicts  out  CNT_W  count of mispredicted instructions

Behaviour:
- Index: IDX_W = log2(BHT_ENTRIES); idx = pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Prediction: f_pred_taken = bht[idx(f_pc)][1]. Pure read with no bypass; a same-cycle write to the same entry becomes visible the next cycle.
- Resolution when ex_valid=0: ex_taken=0, ex_mispredict=0, no table or counter update.
- Resolution when ex_brop[4]=1: ex_taken=1 regardless of bit 3. No BHT update.
- Resolution when ex_brop[4]=0 and ex_brop[3]=1 (conditional), by ex_brop[2:0]:
  - 000 BEQ: a==b
  - 001 BNE: a!=b
  - 100 BLT: signed a<b
  - 101 BGE: signed a>=b
  - 110 BLTU: unsigned a<b
  - 111 BGEU: unsigned a>=b
  - 010, 011: ex_taken=0, treated as non-branch, no update, not counted
- Resolution when ex_brop[4:3]=00: ex_taken=0, no update.
- All compares are full XLEN width.
- BHT training, on a rising edge with a valid, legal conditional branch:
  - taken: counter increments, saturating at 11
  - not taken: counter decrements, saturating at 00
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Performance counters, each saturating at all-ones with no wrap:
  - perf_branches increments on each valid legal conditional branch.
  - perf_mispredicts increments on each cycle where ex_mispredict=1 (jumps included).
  - clr_stats has priority over an increment in the same cycle; both counters read 0 on the next cycle.
- Reset (rst_n low, asynchronous):
  - every BHT entry = 01
  - perf counters = 0
  - f_pred_taken therefore reads 0 for every PC
  - Reset asserted mid-update: the update is discarded and the table is in reset state on release.
- Latency: resolution outputs have 0 cycles latency; table and counter effects appear 1 cycle after the update edge.

Decomposition:
- Shared package core_pkg:
  - XLEN default
  - BrOp field positions
  - funct3 localparams: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - typedef for the 2-bit counter state, with constants SNT, WNT, WT, ST
- Sub-module sat_counter2: a single 2-bit saturating up/down counter with enable and async reset to WNT, instantiated BHT_ENTRIES times.
- The compare logic stays inline.

Test Plan:
- Reset, then f_pc=0x100 -> f_pred_taken=0; perf_branches=0, perf_mispredicts=0.
- BEQ with a=b=5, ex_pc=0x100, ex_pred_taken=0 -> ex_taken=1, ex_mispredict=1. Next cycle f_pc=0x100 predicts 1 (entry 10). perf_branches=1, perf_mispredicts=1.
- BLT with a=0xFFFFFFFF, b=1 -> taken. BLTU with the same operands -> not taken. BGEU with the same operands -> taken.
- Three taken branches at 0x200, then three not-taken -> entry goes 01→10→11→11, then 10→01→00; predictions follow bit 1.
- Jump (brop=10000) with ex_pred_taken=0 -> ex_taken=1, ex_mispredict=1, BHT unchanged, perf_branches unchanged.
- brop=01010 (illegal funct3) -> taken=0, no update. Preload perf_branches to all-ones via a forced counter, apply a branch -> value holds. Then assert clr_stats and an increment together -> counter reads 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core constants, branch-op fields and the 2-bit BHT counter state
package core_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int BROP_JUMP = 4;
  localparam int BROP_COND = 3;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_state_t;
endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// sat_counter2: 2-bit saturating up/down counter, async reset to WNT
// ports: clk, rst_n; en_i enables a step; up_i selects increment (1) or decrement (0); q_o is the state
module sat_counter2
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       up_i,
  output bht_state_t q_o
);
  bht_state_t q_q, q_d;
  logic [1:0] inc, dec;
  assign inc = q_q + 2'd1;
  assign dec = q_q - 2'd1;
  always_comb q_d = !en_i ? q_q : up_i ? (q_q == ST ? ST : bht_state_t'(inc)) : (q_q == SNT ? SNT : bht_state_t'(dec));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= WNT;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch resolve/compare, bimodal BHT prediction and training, perf counters
// ports: f_pc -> f_pred_taken (fetch lookup); ex_* resolve a branch/jump -> ex_taken, ex_mispredict;
//        clr_stats clears perf_branches / perf_mispredicts
module branch_predict_unit
  import core_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_a,
  input  logic [XLEN-1:0]  ex_b,
  input  logic [4:0]       ex_brop,
  input  logic             ex_pred_taken,
  output logic             ex_taken,
  output logic             ex_mispredict,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  bht_state_t bht [BHT_ENTRIES];
  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [2:0] f3;
  logic eq, lt, ltu, cond_taken, legal, is_br;
  logic [CNT_W-1:0] br_q, br_d, mp_q, mp_d;
  assign f_idx = f_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign f3 = ex_brop[2:0];
  assign eq = ex_a == ex_b;
  assign lt = $signed(ex_a) < $signed(ex_b);
  assign ltu = ex_a < ex_b;
  assign cond_taken = f3 == F3_BEQ ? eq : f3 == F3_BNE ? !eq : f3 == F3_BLT ? lt :
                      f3 == F3_BGE ? !lt : f3 == F3_BLTU ? ltu : f3 == F3_BGEU ? !ltu : 1'b0;
  // funct3 010/011 are not branches
  assign legal = f3[2:1] != 2'b01;
  assign is_br = ex_valid & !ex_brop[BROP_JUMP] & ex_brop[BROP_COND] & legal;
  assign ex_taken = (ex_valid & ex_brop[BROP_JUMP]) | (is_br & cond_taken);
  assign ex_mispredict = ex_valid & (ex_taken != ex_pred_taken);
  assign f_pred_taken = bht[f_idx][1];
  for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
    sat_counter2 u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .en_i (is_br && ex_idx == IDX_W'(g)),
      .up_i (cond_taken),
      .q_o  (bht[g])
    );
  end
  always_comb begin
    br_d = clr_stats ? '0 : (is_br && !(&br_q)) ? br_q + CNT_W'(1) : br_q;
    mp_d = clr_stats ? '0 : (ex_mispredict && !(&mp_q)) ? mp_q + CNT_W'(1) : mp_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  assign perf_branches = br_q;
  assign perf_mispredicts = mp_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench with a behavioural predictor/resolver model
module tb_branch_predict_unit;
  localparam int XLEN = 32, ENT = 16, IW = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0;
  logic [XLEN-1:0] f_pc = '0, ex_pc = '0, ex_a = '0, ex_b = '0;
  logic [4:0] ex_brop = '0;
  logic ex_valid = 0, ex_pred_taken = 0, clr_stats = 0;
  logic f_pred_taken, ex_taken, ex_mispredict;
  logic [CW-1:0] perf_branches, perf_mispredicts;
  always #5 clk = ~clk;
  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(ENT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_brop(ex_brop),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
    .clr_stats(clr_stats), .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );
  typedef struct {
    logic taken, mis, fpred;
    int pb, pm;
  } exp_t;
  exp_t q[$];
  int bht_m[ENT];
  int pb_m, pm_m;
  int compared = 0, mismatched = 0;
  function automatic int idx(logic [XLEN-1:0] pc);
    return int'(pc[IW+1:2]);
  endfunction
  task automatic model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    pb_m = 0;
    pm_m = 0;
  endtask
  task automatic check(string n, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [XLEN-1:0] pc, a, b, input logic [4:0] op,
                      input logic pt, input logic [XLEN-1:0] fpc, input logic c);
    exp_t e;
    logic br, t;
    ex_valid = v; ex_pc = pc; ex_a = a; ex_b = b; ex_brop = op;
    ex_pred_taken = pt; f_pc = fpc; clr_stats = c;
    case (op[2:0])
      3'd0: t = a == b;
      3'd1: t = a != b;
      3'd4: t = $signed(a) < $signed(b);
      3'd5: t = $signed(a) >= $signed(b);
      3'd6: t = a < b;
      3'd7: t = a >= b;
      default: t = 0;
    endcase
    br = v && !op[4] && op[3] && !(op[2:0] inside {3'b010, 3'b011});
    e.taken = v && (op[4] || (br && t));
    e.mis = v && (e.taken != pt);
    e.fpred = bht_m[idx(fpc)] >= 2;
    e.pb = pb_m;
    e.pm = pm_m;
    q.push_back(e);
    if (br) bht_m[idx(pc)] = t ? (bht_m[idx(pc)] < 3 ? bht_m[idx(pc)] + 1 : 3)
                               : (bht_m[idx(pc)] > 0 ? bht_m[idx(pc)] - 1 : 0);
    pb_m = c ? 0 : (br && pb_m < CMAX) ? pb_m + 1 : pb_m;
    pm_m = c ? 0 : (e.mis && pm_m < CMAX) ? pm_m + 1 : pm_m;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic [XLEN-1:0] fpc);
    step(0, '0, '0, '0, 5'b00000, 0, fpc, 0);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ex_taken", int'(ex_taken), int'(e.taken));
      check("ex_mispredict", int'(ex_mispredict), int'(e.mis));
      check("f_pred_taken", int'(f_pred_taken), int'(e.fpred));
      check("perf_branches", int'(perf_branches), e.pb);
      check("perf_mispredicts", int'(perf_mispredicts), e.pm);
    end
  initial begin
    logic [XLEN-1:0] ra, rb, rpc;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle(32'h100);
    step(1, 32'h100, 5, 5, 5'b01000, 0, 32'h100, 0);
    idle(32'h100);
    step(1, 32'h300, 32'hFFFF_FFFF, 1, 5'b01100, 0, 32'h300, 0);
    step(1, 32'h300, 32'hFFFF_FFFF, 1, 5'b01110, 1, 32'h300, 0);
    step(1, 32'h300, 32'hFFFF_FFFF, 1, 5'b01111, 0, 32'h300, 0);
    step(1, 32'h300, 32'h8000_0000, 32'h7FFF_FFFF, 5'b01101, 1, 32'h300, 0);
    step(1, 32'h300, 3, 3, 5'b01001, 1, 32'h300, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h204, 7, 7, 5'b01000, 1, 32'h204, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h204, 7, 8, 5'b01000, 0, 32'h204, 0);
    idle(32'h204);
    step(1, 32'h208, 0, 0, 5'b10000, 0, 32'h208, 0);
    step(1, 32'h208, 0, 1, 5'b11000, 1, 32'h208, 0);
    step(1, 32'h208, 0, 1, 5'b01010, 1, 32'h208, 0);
    step(1, 32'h208, 0, 1, 5'b01011, 0, 32'h208, 0);
    step(1, 32'h208, 4, 4, 5'b00000, 1, 32'h208, 0);
    step(0, 32'h208, 4, 4, 5'b01000, 1, 32'h208, 0);
    idle(32'h208);
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : ($urandom_range(0, 1) ? $urandom : ra + $urandom_range(0, 2) - 1);
      rpc = {22'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 4'($urandom)};
      step($urandom_range(0, 7) != 0, rpc, ra, rb, 5'($urandom),
           1'($urandom), {$urandom_range(0, 255), 2'($urandom)}, $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 20; i++) step(1, 32'h40, 9, 9, 5'b01000, 0, 32'h40, 0);
    step(1, 32'h40, 9, 9, 5'b01000, 0, 32'h40, 1);
    idle(32'h40);
    step(1, 32'h0, 1, 1, 5'b01000, 1, 32'h0, 0);
    step(1, 32'h0, 1, 1, 5'b01000, 0, 32'h0, 0);
    idle(32'h0);
    ex_valid = 1; ex_pc = 32'h0; ex_a = 0; ex_b = 0; ex_brop = 5'b01000; ex_pred_taken = 0;
    @(negedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 ex_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    idle(32'h0);
    idle(32'h40);
    idle(32'h204);
    @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
